// File: rtl/mips_pkg.sv
// Shared MIPS fetch-stage types: word-address width, default vectors and
// the pc_sequencer state encoding.
package mips_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam word_t DEFAULT_EXC_VECTOR = 32'h0000_0020;

  // ST_PEND is only reachable when the branch-delay-slot build is enabled.
  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STALL = 3'd2,
    ST_FLUSH = 3'd3,
    ST_PEND  = 3'd4
  } pc_state_e;

endpackage

// File: rtl/incrementer_32b.sv
// 32-bit incrementer used for sequential PC advance; wraps modulo 2^32.
import mips_pkg::*;

module incrementer_32b (
  input  word_t a,
  output word_t y
);

  // Carry out of bit 31 is intentionally dropped: all-ones wraps to zero.
  assign y = a + word_t'(1);

endmodule

// File: rtl/pc_sequencer.sv
// MIPS fetch-stage program counter sequencer.
// Chooses each cycle between sequential advance, hold, redirect and
// exception vectoring; drives the fetch request and the IF/ID flush pulse.
// Optional build macro: DELAY_SLOT_EN (MIPS branch delay slot via ST_PEND).
//
// Fetch handshake: a request is offered while fetch_valid=1 and is taken on
// a rising edge where fetch_valid && fetch_ready. Once offered, pc and
// fetch_valid stay stable until taken, unless a stall, redirect or
// exception intervenes.
import mips_pkg::*;

module pc_sequencer #(
  parameter word_t RESET_PC   = DEFAULT_RESET_PC,
  parameter word_t EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      stall,
  input  logic      redirect_valid,
  input  word_t     redirect_pc,
  input  logic      exc_valid,
  input  logic      fetch_ready,
  output word_t     pc,
  output logic      fetch_valid,
  output logic      flush,
  output pc_state_e state_dbg
);

  pc_state_e state, state_n;
  word_t     pc_n;
  word_t     pc_plus1;
  logic      fetch_valid_n;
  logic      flush_n;
  logic      accepted;

`ifdef DELAY_SLOT_EN
  word_t     pend_q, pend_n;
`endif

  incrementer_32b u_incr (
    .a (pc),
    .y (pc_plus1)
  );

  assign accepted  = fetch_valid && fetch_ready;
  assign state_dbg = state;

  // Next-state and next-output selection; exception beats redirect beats stall.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    flush_n = 1'b0;
`ifdef DELAY_SLOT_EN
    pend_n  = pend_q;
`endif
    if (exc_valid) begin
      pc_n    = EXC_VECTOR;
      flush_n = 1'b1;
      state_n = ST_FLUSH;
`ifdef DELAY_SLOT_EN
      pend_n  = '0;
`endif
    end
`ifdef DELAY_SLOT_EN
    else if (redirect_valid && (state == ST_RUN || state == ST_PEND)) begin
      // Delayed branch: the slot after the current fetch still issues.
      if (state == ST_PEND && accepted && !stall) begin
        pc_n    = redirect_pc;
        state_n = ST_RUN;
      end else begin
        pend_n  = redirect_pc;
        state_n = ST_PEND;
        if (state == ST_RUN && accepted && !stall) begin
          pc_n = pc_plus1;
        end
      end
    end
`endif
    else if (redirect_valid) begin
      pc_n    = redirect_pc;
      flush_n = 1'b1;
      state_n = ST_FLUSH;
    end else begin
      case (state)
        ST_BOOT:  state_n = ST_RUN;
        ST_RUN: begin
          if (stall) begin
            state_n = ST_STALL;
          end else if (accepted) begin
            pc_n = pc_plus1;
          end
        end
        ST_STALL: begin
          if (!stall) begin
            state_n = ST_RUN;
          end
        end
        ST_FLUSH: state_n = ST_RUN;
`ifdef DELAY_SLOT_EN
        ST_PEND: begin
          if (accepted && !stall) begin
            pc_n    = pend_q;
            state_n = ST_RUN;
          end
        end
`endif
        default:  state_n = ST_BOOT;
      endcase
    end
    fetch_valid_n = (state_n == ST_RUN) || ((state_n == ST_PEND) && !stall);
  end

  // State and registered outputs; reset aborts anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      fetch_valid <= fetch_valid_n;
      flush       <= flush_n;
    end
  end

`ifdef DELAY_SLOT_EN
  // Pending delayed-branch target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_n;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with hand-computed expectations.
import mips_pkg::*;

module tb_pc_sequencer;

  logic      clk;
  logic      rst_n;
  logic      stall;
  logic      redirect_valid;
  word_t     redirect_pc;
  logic      exc_valid;
  logic      fetch_ready;
  word_t     pc;
  logic      fetch_valid;
  logic      flush;
  pc_state_e state_dbg;

  int n_compared   = 0;
  int n_mismatched = 0;

  pc_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_valid      (exc_valid),
    .fetch_ready    (fetch_ready),
    .pc             (pc),
    .fetch_valid    (fetch_valid),
    .flush          (flush),
    .state_dbg      (state_dbg)
  );

  // Clock: 10 time units, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc_e,
                            input logic fv_e, input logic fl_e);
    check({tag, ".pc"}, pc, pc_e);
    check({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, fv_e});
    check({tag, ".flush"}, {31'd0, flush}, {31'd0, fl_e});
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    exc_valid      = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    fetch_ready = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 32'h0, 1'b0, 1'b0);
    check("reset.state", {29'd0, state_dbg}, {29'd0, ST_BOOT});

    // Release: BOOT cycle, then sequential fetch.
    rst_n = 1'b1;
    #1;
    expect_out("boot", 32'h0, 1'b0, 1'b0);
    step(); expect_out("seq0", 32'h0, 1'b1, 1'b0);
    step(); expect_out("seq1", 32'h1, 1'b1, 1'b0);
    step(); expect_out("seq2", 32'h2, 1'b1, 1'b0);
    step(); expect_out("seq3", 32'h3, 1'b1, 1'b0);
    step(); step();
    expect_out("seq5", 32'h5, 1'b1, 1'b0);

    // Memory back-pressure holds the request.
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("hold5", 32'h5, 1'b1, 1'b0);
    end
    fetch_ready = 1'b1;
    step(); expect_out("resume6", 32'h6, 1'b1, 1'b0);
    step(); expect_out("seq7", 32'h7, 1'b1, 1'b0);

`ifndef DELAY_SLOT_EN
    // Redirect overrides a simultaneous stall.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    step(); expect_out("redir_load", 32'h100, 1'b0, 1'b1);
    clear_inputs();
    step(); expect_out("redir_tgt", 32'h100, 1'b1, 1'b0);
    step(); expect_out("redir_next", 32'h101, 1'b1, 1'b0);
`else
    step(); step(); step();
    expect_out("seq10", 32'hA, 1'b1, 1'b0);
    // Delayed branch at pc=10: slot 11 issues, then 0x40, no bubble.
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(); expect_out("ds_slot", 32'hB, 1'b1, 1'b0);
    clear_inputs();
    step(); expect_out("ds_tgt", 32'h40, 1'b1, 1'b0);
    step(); expect_out("ds_next", 32'h41, 1'b1, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h50;
    step(); expect_out("ds_slot2", 32'h42, 1'b1, 1'b0);
    clear_inputs();
    exc_valid = 1'b1;
    step(); expect_out("ds_exc", 32'h20, 1'b0, 1'b1);
    clear_inputs();
    step(); expect_out("ds_exc_run", 32'h20, 1'b1, 1'b0);
`endif

    // Exception beats a same-cycle redirect; 0x200 is never fetched.
    exc_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    step(); expect_out("exc_load", 32'h20, 1'b0, 1'b1);
    clear_inputs();
    step(); expect_out("exc_tgt", 32'h20, 1'b1, 1'b0);
    step(); expect_out("exc_next", 32'h21, 1'b1, 1'b0);

    // Redirect while in FLUSH: accepted, flush pulses again.
    exc_valid = 1'b1;
    step(); expect_out("exc2_load", 32'h20, 1'b0, 1'b1);
    clear_inputs();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step(); expect_out("flush_redir", 32'hFFFF_FFFF, 1'b0, 1'b1);
    clear_inputs();
    step(); expect_out("wrap_fetch", 32'hFFFF_FFFF, 1'b1, 1'b0);
    step(); expect_out("wrap_zero", 32'h0, 1'b1, 1'b0);

    // Stall: bubble while held, same pc fetched after release.
    stall = 1'b1;
    step(); expect_out("stall1", 32'h0, 1'b0, 1'b0);
    step(); expect_out("stall2", 32'h0, 1'b0, 1'b0);
    check("stall.state", {29'd0, state_dbg}, {29'd0, ST_STALL});
    stall = 1'b0;
    step(); expect_out("unstall", 32'h0, 1'b1, 1'b0);
    step(); expect_out("unstall_next", 32'h1, 1'b1, 1'b0);

    // Asynchronous reset aborts a pending redirect.
    redirect_valid = 1'b1; redirect_pc = 32'h999;
    #2 rst_n = 1'b0;
    #1 expect_out("async_rst", 32'h0, 1'b0, 1'b0);
    step(); expect_out("rst_hold", 32'h0, 1'b0, 1'b0);

    // Redirect in BOOT takes the flush path.
    redirect_pc = 32'h77;
    rst_n = 1'b1;
    #1 expect_out("boot2", 32'h0, 1'b0, 1'b0);
    step(); expect_out("boot_redir", 32'h77, 1'b0, 1'b1);
    clear_inputs();
    step(); expect_out("boot_tgt", 32'h77, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
